// File: rtl/ans_freq_model.sv
// Frequency table for an ANS encoder: loads per-symbol counts, builds cumulative
// sums serially, then maps each incoming symbol to (count, cumulative) at one per cycle.
//
// state | meaning
// LOAD  | accepting table writes (ld_*), symbols blocked
// BUILD | one symbol per cycle: cum[i] <= running sum, N cycles total
// RUN   | table valid, symbols looked up into the output register
module ans_freq_model #(
  parameter int SYM_WIDTH   = 4,
  parameter int CNT_WIDTH   = 4,
  parameter int STATE_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic                           ld_vld,
  output logic                           ld_rdy,
  input  logic [SYM_WIDTH-1:0]           ld_sym,
  input  logic [CNT_WIDTH-1:0]           ld_cnt,
  input  logic                           ld_last,
  input  logic                           tbl_clr,
  input  logic [SYM_WIDTH-1:0]           sym_in,
  input  logic                           sym_vld,
  output logic                           sym_rdy,
  output logic [CNT_WIDTH-1:0]           s_count,
  output logic [SYM_WIDTH+CNT_WIDTH-1:0] s_cumulative,
  output logic [STATE_WIDTH-1:0]         total_count,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic                           tbl_ready,
  output logic                           err_zero,
  output logic                           err_empty
);

  localparam int N  = 1 << SYM_WIDTH;
  localparam int CW = SYM_WIDTH + CNT_WIDTH;

  typedef enum logic [1:0] {LOAD, BUILD, RUN} state_t;

  state_t state, state_nxt;

  logic [N-1:0][CNT_WIDTH-1:0] cnt;
  logic [N-1:0][CW-1:0]        cum;
  logic [CW-1:0]               acc;
  logic [CW-1:0]               acc_sum;
  logic [SYM_WIDTH-1:0]        idx;
  logic                        clr_go;
  logic                        ld_acc;
  logic                        sym_acc;
  logic                        sym_zero;

  assign acc_sum   = acc + CW'(cnt[idx]);
  assign ld_acc    = ld_vld && ld_rdy;
  assign sym_acc   = sym_vld && sym_rdy;
  assign sym_zero  = (cnt[sym_in] == '0);
  assign tbl_ready = (state == RUN);

  always_comb begin
    state_nxt = state;
    ld_rdy    = 1'b0;
    sym_rdy   = 1'b0;
    clr_go    = ena && (state == RUN) && tbl_clr && !out_vld;
    if (ena) begin
      case (state)
        LOAD: begin
          ld_rdy = 1'b1;
          if (ld_vld && ld_last) state_nxt = BUILD;
        end
        BUILD: begin
          if (idx == '1) state_nxt = (acc_sum != '0) ? RUN : LOAD;
        end
        RUN: begin
          if (clr_go) state_nxt = LOAD;
          else        sym_rdy = !out_vld || out_rdy;
        end
        default: state_nxt = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      cum          <= '0;
      acc          <= '0;
      idx          <= '0;
      total_count  <= '0;
      s_count      <= '0;
      s_cumulative <= '0;
      out_vld      <= 1'b0;
      err_zero     <= 1'b0;
      err_empty    <= 1'b0;
    end else if (ena) begin
      if (ld_acc) cnt[ld_sym] <= ld_cnt;
      if (ld_acc && ld_last) begin
        idx <= '0;
        acc <= '0;
      end

      if (state == BUILD) begin
        cum[idx] <= acc;
        acc      <= acc_sum;
        idx      <= idx + 1'b1;
        if (idx == '1) begin
          total_count <= STATE_WIDTH'(acc_sum);
          if (acc_sum == '0) err_empty <= 1'b1;
        end
      end

      // zero-count symbols are dropped; a pending output may still drain this cycle
      if (sym_acc && !sym_zero) begin
        s_count      <= cnt[sym_in];
        s_cumulative <= cum[sym_in];
        out_vld      <= 1'b1;
      end else if (out_vld && out_rdy) begin
        out_vld <= 1'b0;
      end
      if (sym_acc && sym_zero) err_zero <= 1'b1;

      if (clr_go) begin
        cnt       <= '0;
        err_zero  <= 1'b0;
        err_empty <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ans_freq_model.sv
// Directed test of ans_freq_model: load/build, lookup throughput, backpressure,
// zero-count drop, empty table, clear, reset mid-build and enable gating.
module tb_ans_freq_model;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        ld_vld;
  logic        ld_rdy;
  logic [3:0]  ld_sym;
  logic [3:0]  ld_cnt;
  logic        ld_last;
  logic        tbl_clr;
  logic [3:0]  sym_in;
  logic        sym_vld;
  logic        sym_rdy;
  logic [3:0]  s_count;
  logic [7:0]  s_cumulative;
  logic [15:0] total_count;
  logic        out_vld;
  logic        out_rdy;
  logic        tbl_ready;
  logic        err_zero;
  logic        err_empty;

  int n_chk  = 0;
  int n_fail = 0;

  ans_freq_model #(.SYM_WIDTH(4), .CNT_WIDTH(4), .STATE_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_sym(ld_sym), .ld_cnt(ld_cnt), .ld_last(ld_last),
    .tbl_clr(tbl_clr), .sym_in(sym_in), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
    .s_count(s_count), .s_cumulative(s_cumulative), .total_count(total_count),
    .out_vld(out_vld), .out_rdy(out_rdy), .tbl_ready(tbl_ready),
    .err_zero(err_zero), .err_empty(err_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [3:0] s, input logic [3:0] c, input logic last);
    ld_vld  = 1'b1;
    ld_sym  = s;
    ld_cnt  = c;
    ld_last = last;
    tick();
    ld_vld  = 1'b0;
    ld_last = 1'b0;
  endtask

  // BUILD lasts 16 cycles: still building after 15, finished after 16
  task automatic wait_build(input string tag);
    repeat (15) tick();
    chk({tag, "_build_busy"}, ld_rdy, 0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ld_vld = 1'b0; ld_sym = '0; ld_cnt = '0; ld_last = 1'b0;
    tbl_clr = 1'b0; sym_in = '0; sym_vld = 1'b0; out_rdy = 1'b0;
    #3;
    chk("rst_tbl_ready", tbl_ready, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_total", total_count, 0);
    chk("rst_ld_rdy", ld_rdy, 1);
    chk("rst_sym_rdy", sym_rdy, 0);
    tick(); tick();
    rst_n = 1'b1;

    // table {0:3, 1:1, 2:4}; tbl_clr during BUILD must be ignored
    ld(4'd0, 4'd3, 1'b0);
    ld(4'd1, 4'd1, 1'b0);
    ld(4'd2, 4'd4, 1'b1);
    chk("build_ld_rdy", ld_rdy, 0);
    tbl_clr = 1'b1;
    repeat (5) tick();
    tbl_clr = 1'b0;
    repeat (10) tick();
    chk("build1_busy", tbl_ready, 0);
    tick();
    chk("build1_ready", tbl_ready, 1);
    chk("build1_total", total_count, 8);

    // back-to-back lookups at full throughput
    out_rdy = 1'b1; sym_vld = 1'b1; sym_in = 4'd2;
    #1 chk("run_sym_rdy", sym_rdy, 1);
    tick();
    chk("s2_vld", out_vld, 1);
    chk("s2_count", s_count, 4);
    chk("s2_cum", s_cumulative, 4);
    sym_in = 4'd0;
    tick();
    chk("s0_vld", out_vld, 1);
    chk("s0_count", s_count, 3);
    chk("s0_cum", s_cumulative, 0);
    sym_vld = 1'b0;
    tick();
    chk("drain_vld", out_vld, 0);

    // backpressure
    out_rdy = 1'b0; sym_vld = 1'b1; sym_in = 4'd1;
    tick();
    sym_in = 4'd2;
    #1 chk("bp_sym_rdy", sym_rdy, 0);
    tick(); tick();
    chk("bp_vld", out_vld, 1);
    chk("bp_count", s_count, 1);
    chk("bp_cum", s_cumulative, 3);
    out_rdy = 1'b1;
    #1 chk("bp_release_rdy", sym_rdy, 1);
    tick();
    chk("bp_next_vld", out_vld, 1);
    chk("bp_next_count", s_count, 4);
    chk("bp_next_cum", s_cumulative, 4);
    sym_vld = 1'b0;
    tick();
    chk("bp_drain", out_vld, 0);

    // zero-count symbol dropped
    sym_vld = 1'b1; sym_in = 4'd5;
    tick();
    chk("zero_vld", out_vld, 0);
    chk("zero_err", err_zero, 1);
    sym_in = 4'd1;
    tick();
    chk("after_zero_vld", out_vld, 1);
    chk("after_zero_count", s_count, 1);
    chk("after_zero_cum", s_cumulative, 3);
    chk("zero_err_sticky", err_zero, 1);
    sym_vld = 1'b0;
    tick();

    // tbl_clr ignored while output pending, then taken
    out_rdy = 1'b0; sym_vld = 1'b1; sym_in = 4'd0;
    tick();
    sym_vld = 1'b0; tbl_clr = 1'b1;
    tick();
    chk("clr_pending_ignored", tbl_ready, 1);
    out_rdy = 1'b1;
    tick();
    chk("clr_drained", out_vld, 0);
    sym_vld = 1'b1; sym_in = 4'd1;
    #1 chk("clr_blocks_sym", sym_rdy, 0);
    tick();
    tbl_clr = 1'b0; sym_vld = 1'b0;
    chk("clr_to_load", tbl_ready, 0);
    chk("clr_ld_rdy", ld_rdy, 1);
    chk("clr_err_zero", err_zero, 0);
    chk("clr_out_vld", out_vld, 0);

    // empty table
    ld(4'd3, 4'd0, 1'b1);
    wait_build("empty");
    chk("empty_err", err_empty, 1);
    chk("empty_state", tbl_ready, 0);
    chk("empty_ld_rdy", ld_rdy, 1);
    chk("empty_total", total_count, 0);

    // full-scale table, with sym 3 overwritten 2 -> 15
    ld(4'd3, 4'd2, 1'b0);
    for (int k = 0; k < 16; k++) ld(4'(k), 4'd15, k == 15);
    wait_build("full");
    chk("full_ready", tbl_ready, 1);
    chk("full_total", total_count, 240);
    chk("full_err_empty_sticky", err_empty, 1);
    out_rdy = 1'b1; sym_vld = 1'b1; sym_in = 4'd15;
    tick();
    chk("s15_count", s_count, 15);
    chk("s15_cum", s_cumulative, 225);
    sym_in = 4'd3;
    tick();
    chk("s3_count", s_count, 15);
    chk("s3_cum", s_cumulative, 45);
    sym_vld = 1'b0;
    tick();
    tbl_clr = 1'b1;
    tick();
    tbl_clr = 1'b0;
    chk("clr2_load", ld_rdy, 1);

    // reset in the middle of BUILD
    ld(4'd0, 4'd3, 1'b0);
    ld(4'd1, 4'd1, 1'b0);
    ld(4'd2, 4'd4, 1'b1);
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ld_rdy", ld_rdy, 1);
    chk("mid_rst_total", total_count, 0);
    chk("mid_rst_count", s_count, 0);
    chk("mid_rst_cum", s_cumulative, 0);
    chk("mid_rst_err", err_empty, 0);
    tick();
    rst_n = 1'b1;

    // enable gating
    ena = 1'b0;
    #1 chk("ena0_ld_rdy", ld_rdy, 0);
    ena = 1'b1;
    ld(4'd0, 4'd3, 1'b0);
    ld(4'd1, 4'd1, 1'b0);
    ld(4'd2, 4'd4, 1'b1);
    wait_build("rebuild");
    chk("rebuild_ready", tbl_ready, 1);
    chk("rebuild_total", total_count, 8);
    out_rdy = 1'b1; sym_vld = 1'b1; sym_in = 4'd2;
    tick();
    chk("ena_s2_vld", out_vld, 1);
    ena = 1'b0; sym_in = 4'd0;
    #1 chk("ena0_sym_rdy", sym_rdy, 0);
    tick(); tick();
    chk("ena0_hold_vld", out_vld, 1);
    chk("ena0_hold_count", s_count, 4);
    chk("ena0_hold_ready", tbl_ready, 1);
    ena = 1'b1; sym_vld = 1'b0;
    tick();
    chk("ena1_drain", out_vld, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ans_freq_model.md
ANS_FREQ_MODEL -- requirements
Module: ans_freq_model

Interface
REQ-001 SHALL have parameter SYM_WIDTH, default 4, symbol index width; alphabet size N = 2^SYM_WIDTH.
REQ-002 SHALL have parameter CNT_WIDTH, default 4, per-symbol frequency count width.
REQ-003 SHALL have parameter STATE_WIDTH, default 16, width of total_count and of the downstream encoder state.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named as below.
REQ-005 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- ena, in, 1, global enable.
- ld_vld, in, 1, table write valid.
- ld_rdy, out, 1, table write ready.
- ld_sym, in, SYM_WIDTH, symbol being written.
- ld_cnt, in, CNT_WIDTH, frequency for ld_sym.
- ld_last, in, 1, final table write.
- tbl_clr, in, 1, request return to LOAD.
- sym_in, in, SYM_WIDTH, symbol to encode.
- sym_vld, in, 1, symbol valid.
- sym_rdy, out, 1, symbol ready.
- s_count, out, CNT_WIDTH, frequency of the accepted symbol.
- s_cumulative, out, SYM_WIDTH+CNT_WIDTH, sum of counts of all lower-indexed symbols.
- total_count, out, STATE_WIDTH, sum of all counts, zero-extended.
- out_vld, in/out: out, 1, output valid.
- out_rdy, in, 1, downstream (encoder) ready.
- tbl_ready, out, 1, high in RUN.
- err_zero, out, 1, sticky: zero-count symbol dropped.
- err_empty, out, 1, sticky: table built with total 0.

Function
REQ-006 SHALL implement states LOAD, BUILD, RUN.
REQ-007 SHALL hold cnt[0..N-1] (CNT_WIDTH each) and cum[0..N-1] (SYM_WIDTH+CNT_WIDTH each) in registers.
REQ-008 When ena=0, SHALL change no register and SHALL drive ld_rdy=0 and sym_rdy=0; other outputs hold.
REQ-009 In LOAD: ld_rdy=1, sym_rdy=0; write accepted when ld_vld&&ld_rdy; cnt[ld_sym]<=ld_cnt; repeated writes to the same symbol keep the last value.
REQ-010 An accepted write with ld_last=1 SHALL enter BUILD next cycle; index i<=0, accumulator acc<=0.
REQ-011 In BUILD: ld_rdy=0, sym_rdy=0; each cycle cum[i]<=acc, acc<=acc+cnt[i], i<=i+1; exactly N cycles.
REQ-012 On the BUILD cycle with i=N-1, SHALL latch total_count<=final sum (acc+cnt[N-1]); if the sum is nonzero, go to RUN, else set err_empty and go to LOAD.
REQ-013 acc SHALL be SYM_WIDTH+CNT_WIDTH bits wide; maximum sum N*(2^CNT_WIDTH-1) SHALL NOT overflow.
REQ-014 In RUN: sym_rdy = !out_vld || out_rdy; single-entry output register; full throughput of one symbol per cycle.
REQ-015 On accept of sym_in with cnt[sym_in]!=0: next cycle s_count<=cnt[sym_in], s_cumulative<=cum[sym_in], out_vld<=1; latency 1 cycle.
REQ-016 On accept of sym_in with cnt[sym_in]=0: SHALL drop the symbol and set err_zero; out_vld is cleared if out_rdy consumed the pending output, otherwise unchanged.
REQ-017 out_vld&&out_rdy with no new accept SHALL clear out_vld; simultaneous consume and accept SHALL replace the output data, keeping out_vld=1.
REQ-018 s_count and s_cumulative SHALL be stable while out_vld=1 and out_rdy=0.
REQ-019 tbl_clr in RUN with out_vld=0 SHALL, in that cycle, block symbol accepts (sym_rdy=0), then enter LOAD with all cnt cleared and err_zero/err_empty cleared; tbl_clr while out_vld=1 SHALL be ignored; tbl_clr in LOAD/BUILD SHALL be ignored.
REQ-020 tbl_ready SHALL be 1 exactly in RUN.

Reset
REQ-021 rst_n low SHALL immediately force: state LOAD; all cnt, cum, acc, i = 0; total_count=0; s_count=0; s_cumulative=0; out_vld=0; err_zero=0; err_empty=0; tbl_ready=0.
REQ-022 Reset asserted in BUILD or RUN SHALL discard partial sums and any pending output.

Verification
REQ-023 Load cnt{0:3,1:1,2:4}, ld_last on sym 2 -> BUILD lasts 16 cycles; tbl_ready rises; total_count=8; cum[3..15]=8.
REQ-024 In RUN, send sym 2 then sym 0 with out_rdy=1 -> cycle+1: s_count=4, s_cumulative=4; cycle+2: s_count=3, s_cumulative=0; out_vld held high.
REQ-025 out_rdy=0, send sym 1 then present sym 2 -> s_count=1, s_cumulative=3 held; sym_rdy=0; sym 2 is accepted on the cycle out_rdy=1.
REQ-026 Send sym 5 (count 0) -> no out_vld; err_zero=1 and stays 1; the next sym 1 is output normally.
REQ-027 Load only ld_cnt=0 with ld_last -> after 16 BUILD cycles: err_empty=1, state LOAD, ld_rdy=1.
REQ-028 Reset at BUILD cycle 7, then toggle ena low mid-RUN -> after reset all outputs are 0 and state is LOAD; with ena=0 nothing advances and sym_rdy=0.
